// File: rtl/midi_pkg.sv
// rtl/midi_pkg.sv - shared MIDI event types, status constants and message-length helper
package midi_pkg;

   typedef enum logic [1:0] {
      EV_NOTE_OFF   = 2'd0,
      EV_NOTE_ON    = 2'd1,
      EV_CC         = 2'd2,
      EV_PITCH_BEND = 2'd3
   } event_type_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_D1    = 2'd1,
      S_D2    = 2'd2,
      S_SYSEX = 2'd3
   } parse_state_t;

   localparam logic [3:0] ST_NOTE_OFF   = 4'h8;
   localparam logic [3:0] ST_NOTE_ON    = 4'h9;
   localparam logic [3:0] ST_POLY_AT    = 4'hA;
   localparam logic [3:0] ST_CC         = 4'hB;
   localparam logic [3:0] ST_PROGRAM    = 4'hC;
   localparam logic [3:0] ST_CHAN_AT    = 4'hD;
   localparam logic [3:0] ST_PITCH_BEND = 4'hE;

   localparam logic [7:0] SYSEX_START = 8'hF0;
   localparam logic [7:0] SYSEX_END   = 8'hF7;
   localparam logic [7:0] RT_MIN      = 8'hF8;

   function automatic logic [1:0] msg_len(input logic [7:0] status);
      if (status[7:4] == ST_PROGRAM || status[7:4] == ST_CHAN_AT)
         return 2'd1;
      return 2'd2;
   endfunction

endpackage

// File: rtl/midi_byte_classify.sv
// rtl/midi_byte_classify.sv - combinational MIDI byte class decoder
import midi_pkg::*;

module midi_byte_classify (
   input  logic [7:0] byte_in,
   output logic       is_realtime,
   output logic       is_sysex_start,
   output logic       is_system,
   output logic       is_status,
   output logic       is_data
);

   assign is_realtime    = (byte_in >= RT_MIN);
   assign is_sysex_start = (byte_in == SYSEX_START);
   assign is_system      = (byte_in > SYSEX_START) && (byte_in <= SYSEX_END);
   assign is_status      = byte_in[7] && (byte_in < SYSEX_START);
   assign is_data        = !byte_in[7];

endmodule

// File: rtl/midi_parser.sv
// rtl/midi_parser.sv - MIDI byte stream to channel event decoder with running status
import midi_pkg::*;

module midi_parser #(
   parameter bit         OMNI    = 1'b1,
   parameter logic [3:0] CHANNEL = 4'd0
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid_in,
   output logic        event_valid_out,
   output event_type_t event_type_out,
   output logic [3:0]  channel_out,
   output logic [6:0]  data1_out,
   output logic [6:0]  data2_out,
   output logic [7:0]  err_count_out
);

   logic is_realtime, is_sysex_start, is_system, is_status, is_data;

   midi_byte_classify u_classify (
      .byte_in        (byte_in),
      .is_realtime    (is_realtime),
      .is_sysex_start (is_sysex_start),
      .is_system      (is_system),
      .is_status      (is_status),
      .is_data        (is_data)
   );

   parse_state_t state, state_next;
   logic [7:0]   status_q, status_next;
   logic [6:0]   data1_q, data1_next;
   logic         emit, err_inc, chan_pass;
   event_type_t  ev_type;

   assign chan_pass = OMNI || (status_q[3:0] == CHANNEL);

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state    <= S_IDLE;
         status_q <= 8'h00;
         data1_q  <= 7'h00;
      end else begin
         state    <= state_next;
         status_q <= status_next;
         data1_q  <= data1_next;
      end
   end

   // Real-time bytes fall through untouched so they are invisible mid-message.
   always_comb begin
      state_next  = state;
      status_next = status_q;
      data1_next  = data1_q;
      emit        = 1'b0;
      err_inc     = 1'b0;
      ev_type     = EV_NOTE_OFF;
      if (byte_valid_in && !is_realtime) begin
         if (is_status) begin
            status_next = byte_in;
            state_next  = S_D1;
         end else if (is_sysex_start) begin
            status_next = 8'h00;
            state_next  = S_SYSEX;
         end else if (is_system) begin
            status_next = 8'h00;
            state_next  = S_IDLE;
         end else if (is_data) begin
            case (state)
               S_IDLE:  err_inc = 1'b1;
               S_D1: begin
                  data1_next = byte_in[6:0];
                  state_next = (msg_len(status_q) == 2'd1) ? S_D1 : S_D2;
               end
               S_D2: begin
                  state_next = S_D1;
                  case (status_q[7:4])
                     ST_NOTE_OFF: begin
                        emit    = chan_pass;
                        ev_type = EV_NOTE_OFF;
                     end
                     ST_NOTE_ON: begin
                        emit    = chan_pass;
                        ev_type = (byte_in[6:0] == 7'd0) ? EV_NOTE_OFF : EV_NOTE_ON;
                     end
                     ST_CC: begin
                        emit    = chan_pass;
                        ev_type = EV_CC;
                     end
                     ST_PITCH_BEND: begin
                        emit    = chan_pass;
                        ev_type = EV_PITCH_BEND;
                     end
                     default: emit = 1'b0;
                  endcase
               end
               S_SYSEX: err_inc = 1'b0;
               default: state_next = S_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         event_valid_out <= 1'b0;
         event_type_out  <= EV_NOTE_OFF;
         channel_out     <= 4'd0;
         data1_out       <= 7'd0;
         data2_out       <= 7'd0;
         err_count_out   <= 8'd0;
      end else begin
         event_valid_out <= emit;
         if (emit) begin
            event_type_out <= ev_type;
            channel_out    <= status_q[3:0];
            data1_out      <= data1_q;
            data2_out      <= byte_in[6:0];
         end
         if (err_inc && err_count_out != 8'hFF)
            err_count_out <= err_count_out + 8'd1;
      end
   end

endmodule

// File: tb/tb_midi_parser.sv
// tb/tb_midi_parser.sv - randomized and directed self-checking bench for midi_parser
import midi_pkg::*;

module tb_midi_parser;

   localparam int F_CH = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, bv;
   logic [7:0]  b;
   logic        ev0, ev1;
   event_type_t ty0, ty1;
   logic [3:0]  ch0, ch1;
   logic [6:0]  a0, a1, d0, d1;
   logic [7:0]  er0, er1;

   midi_parser u_omni (
      .clk_in(clk), .rst_in(rst), .byte_in(b), .byte_valid_in(bv),
      .event_valid_out(ev0), .event_type_out(ty0), .channel_out(ch0),
      .data1_out(a0), .data2_out(d0), .err_count_out(er0)
   );

   midi_parser #(.OMNI(1'b0), .CHANNEL(4'd5)) u_filt (
      .clk_in(clk), .rst_in(rst), .byte_in(b), .byte_valid_in(bv),
      .event_valid_out(ev1), .event_type_out(ty1), .channel_out(ch1),
      .data1_out(a1), .data2_out(d1), .err_count_out(er1)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: running status byte, sysex flag and a queue of collected data bytes
   int m_status;
   bit m_sysex;
   int m_data[$];
   int m_err;
   int ev_count[2];
   bit x_valid[2];
   int x_type[2], x_ch[2], x_d1[2], x_d2[2];
   logic [7:0] seq[$];

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_status = 0;
      m_sysex  = 0;
      m_data.delete();
      m_err    = 0;
      for (int k = 0; k < 2; k++) begin
         x_valid[k] = 0; x_type[k] = 0; x_ch[k] = 0; x_d1[k] = 0; x_d2[k] = 0;
      end
   endfunction

   function automatic void model_byte(input int v);
      int hi, ch, need, t;
      if (v >= 'hF8) return;
      if (v >= 'h80 && v < 'hF0) begin
         m_status = v; m_sysex = 0; m_data.delete();
         return;
      end
      if (v >= 'hF0) begin
         m_status = 0; m_sysex = (v == 'hF0); m_data.delete();
         return;
      end
      if (m_sysex) return;
      if (m_status == 0) begin
         if (m_err < 255) m_err++;
         return;
      end
      m_data.push_back(v);
      hi   = m_status / 16;
      ch   = m_status % 16;
      need = (hi == 12 || hi == 13) ? 1 : 2;
      if (m_data.size() < need) return;
      if (hi == 8 || hi == 9 || hi == 11 || hi == 14) begin
         if (hi == 8)       t = 0;
         else if (hi == 9)  t = (m_data[1] == 0) ? 0 : 1;
         else if (hi == 11) t = 2;
         else               t = 3;
         for (int k = 0; k < 2; k++) begin
            if (k == 0 || ch == F_CH) begin
               x_valid[k] = 1; x_type[k] = t; x_ch[k] = ch;
               x_d1[k] = m_data[0]; x_d2[k] = m_data[1];
            end
         end
      end
      m_data.delete();
   endfunction

   task automatic tick(input bit v, input logic [7:0] val, input bit r);
      @(negedge clk);
      check_eq("omni_valid", int'(ev0), int'(x_valid[0]));
      check_eq("omni_type",  int'(ty0), x_type[0]);
      check_eq("omni_ch",    int'(ch0), x_ch[0]);
      check_eq("omni_d1",    int'(a0),  x_d1[0]);
      check_eq("omni_d2",    int'(d0),  x_d2[0]);
      check_eq("omni_err",   int'(er0), m_err);
      check_eq("filt_valid", int'(ev1), int'(x_valid[1]));
      check_eq("filt_type",  int'(ty1), x_type[1]);
      check_eq("filt_ch",    int'(ch1), x_ch[1]);
      check_eq("filt_d1",    int'(a1),  x_d1[1]);
      check_eq("filt_d2",    int'(d1),  x_d2[1]);
      check_eq("filt_err",   int'(er1), m_err);
      if (ev0) ev_count[0]++;
      if (ev1) ev_count[1]++;
      rst = r; bv = v; b = val;
      x_valid[0] = 0; x_valid[1] = 0;
      if (r) model_reset();
      else if (v) model_byte(int'(val));
   endtask

   task automatic do_reset();
      tick(1'b0, 8'h00, 1'b1);
      tick(1'b0, 8'h00, 1'b0);
      ev_count[0] = 0; ev_count[1] = 0;
   endtask

   task automatic play(input int gap);
      foreach (seq[i]) begin
         tick(1'b1, seq[i], 1'b0);
         for (int g = 0; g < gap; g++) tick(1'b0, 8'h00, 1'b0);
      end
      tick(1'b0, 8'h00, 1'b0);
   endtask

   function automatic logic [7:0] rand_byte();
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 50) return 8'($urandom_range(0, 127));
      if (r < 75) return 8'(8'h80 + $urandom_range(0, 111));
      if (r < 85) return 8'(8'hF8 + $urandom_range(0, 7));
      if (r < 90) return 8'hF0;
      if (r < 95) return 8'hF7;
      return 8'(8'hF1 + $urandom_range(0, 5));
   endfunction

   initial begin
      rst = 1'b1; bv = 1'b0; b = 8'h00;
      model_reset();
      ev_count[0] = 0; ev_count[1] = 0;
      tick(1'b0, 8'h00, 1'b1);
      tick(1'b0, 8'h00, 1'b0);

      do_reset();
      seq = '{8'h90, 8'h3C, 8'h64};
      play(0);
      check_eq("note_on_count", ev_count[0], 1);
      check_eq("note_on_type", int'(ty0), int'(EV_NOTE_ON));
      check_eq("note_on_d1", int'(a0), 'h3C);
      check_eq("note_on_d2", int'(d0), 'h64);

      do_reset();
      seq = '{8'h91, 8'h40, 8'h7F, 8'h40, 8'h00};
      play(2);
      check_eq("running_count", ev_count[0], 2);
      check_eq("running_type", int'(ty0), int'(EV_NOTE_OFF));
      check_eq("running_ch", int'(ch0), 1);

      do_reset();
      seq = '{8'h90, 8'h3C, 8'hF8, 8'h64};
      play(0);
      check_eq("rt_count", ev_count[0], 1);
      check_eq("rt_d2", int'(d0), 'h64);

      do_reset();
      seq = '{8'hF0, 8'h7E, 8'h01, 8'hF7, 8'h3C};
      play(1);
      check_eq("sysex_count", ev_count[0], 0);
      check_eq("orphan_err", int'(er0), 1);
      seq = '{8'hB2, 8'h07, 8'h50};
      play(0);
      check_eq("cc_type", int'(ty0), int'(EV_CC));
      check_eq("cc_ch", int'(ch0), 2);
      seq = '{8'hE0, 8'h00, 8'h40};
      play(0);
      check_eq("pb_type", int'(ty0), int'(EV_PITCH_BEND));
      check_eq("pb_msb", int'(d0), 'h40);

      do_reset();
      seq = '{8'hC3, 8'h05, 8'h90, 8'h3C, 8'h64};
      play(0);
      check_eq("prog_omni_count", ev_count[0], 1);
      check_eq("prog_filt_count", ev_count[1], 0);

      do_reset();
      for (int i = 0; i < 300; i++) tick(1'b1, 8'($urandom_range(0, 127)), 1'b0);
      tick(1'b0, 8'h00, 1'b0);
      check_eq("err_saturate", int'(er0), 255);

      do_reset();
      tick(1'b1, 8'h90, 1'b0);
      tick(1'b1, 8'h3C, 1'b0);
      tick(1'b0, 8'h00, 1'b1);
      tick(1'b1, 8'h64, 1'b0);
      tick(1'b0, 8'h00, 1'b0);
      check_eq("reset_mid_count", ev_count[0], 0);
      check_eq("reset_mid_err", int'(er0), 1);

      tick(1'b1, 8'h3C, 1'b1);
      tick(1'b0, 8'h00, 1'b0);
      check_eq("reset_wins_err", int'(er0), 0);

      for (int i = 0; i < 4000; i++)
         tick($urandom_range(0, 9) < 8, rand_byte(), $urandom_range(0, 199) == 0);
      tick(1'b0, 8'h00, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/midi_parser.md
# midi_parser

Converts the byte stream from the UART RX stage into decoded MIDI channel events for the oscillator stage. Tracks running status, skips SysEx, ignores real-time bytes and reports one event per complete channel message. Sits directly downstream of the UART receiver (31 250 baud MIDI) and upstream of the oscillator/voice logic.

## Interface
- `OMNI`, default 1: 1 = accept all channels; 0 = accept only `CHANNEL`.
- `CHANNEL`, default 0: 4-bit channel filter, used when `OMNI`=0.
- `clk_in` in 1: system clock (100 MHz).
- `rst_in` in 1: reset. One clock; reset is synchronous and active-high.
- `byte_in` in 8: received byte; sampled only when `byte_valid_in`=1.
- `byte_valid_in` in 1: single-cycle strobe from UART RX.
- `event_valid_out` out 1: single-cycle strobe, one per decoded event.
- `event_type_out` out 2: `EV_NOTE_OFF`=0, `EV_NOTE_ON`=1, `EV_CC`=2, `EV_PITCH_BEND`=3.
- `channel_out` out 4: MIDI channel of the event.
- `data1_out` out 7: note / controller number / pitch-bend LSB.
- `data2_out` out 7: velocity / controller value / pitch-bend MSB.
- `err_count_out` out 8: saturating count of orphan data bytes.

## Operation
- Byte classes:
  - real-time: ≥0xF8.
  - SysEx start: 0xF0.
  - other system: 0xF1–0xF7.
  - channel status: 0x80–0xEF.
  - data: <0x80.
- Real-time bytes are discarded in every state, with no change to state, data or running status.
- States:
  - `S_IDLE`: no running status.
  - `S_D1`: awaiting data byte 1.
  - `S_D2`: awaiting data byte 2.
  - `S_SYSEX`: discarding.
- Channel status (any state): latch status, go to `S_D1`, drop any partial message without an event.
- Message length: 0x8_/0x9_/0xA_/0xB_/0xE_ take two data bytes. 0xC_/0xD_ take one; at its completion return to `S_D1`, no event.
- 0xF0 in any state: clear running status, go to `S_SYSEX`.
- 0xF1–0xF7 in any state: clear running status, go to `S_IDLE`. 0xF7 is how `S_SYSEX` normally ends.
- Data bytes:
  - In `S_SYSEX`: ignored.
  - In `S_IDLE`: ignored, `err_count_out` += 1, saturating at 255.
  - In `S_D1`: latch `data1`; go to `S_D2`, or complete the message if it is a one-byte type.
  - In `S_D2`: latch `data2`, complete the message, return to `S_D1` (running status retained).
- On completion, an event is emitted only if the type is 0x8_/0x9_/0xB_/0xE_ and the channel passes the filter.
  - 0x9_ with velocity 0 is reported as `EV_NOTE_OFF`, `data2`=0.
  - 0xA_ (poly aftertouch) completes silently.
- Pitch bend: `data1`=LSB and `data2`=MSB are passed through raw. The consumer forms the 14-bit value as {MSB, LSB}.

## Timing
- Reset values:
  - All outputs 0.
  - State `S_IDLE`, running status cleared, `err_count_out`=0.
- Latency: `event_valid_out` is high for exactly one cycle, in the cycle after the `byte_valid_in` that carried the final data byte. `event_type_out`/`channel_out`/`data*_out` are valid in that cycle and hold their value until the next event.
- One byte per strobe. Strobes on back-to-back cycles must be handled; UART spacing is not relied on.
- No backpressure: the consumer must accept every strobe.
- `rst_in` mid-message: partial message lost, no event, next data byte counts as an error.
- `rst_in` in the same cycle as `byte_valid_in`: reset wins, byte is dropped.
- Reset is assumed only at power-up or from a button; no other recovery is required.

## Structure
- Put `midi_pkg` in a shared package. It holds:
  - `event_type_t` enum.
  - `parse_state_t` enum.
  - Status-nibble constants (`ST_NOTE_OFF`=4'h8 … `ST_PITCH_BEND`=4'hE).
  - `SYSEX_START`=8'hF0, `SYSEX_END`=8'hF7, `RT_MIN`=8'hF8.
  - `function msg_len(status)` returning 1 or 2.
- The oscillator stage imports the same package for `event_type_t`.
- One natural sub-module, `midi_byte_classify` (combinational; `byte_in` → class flags). The FSM, latches and filter stay in `midi_parser`.

## Test plan
- 0x90 0x3C 0x64 → one strobe, `EV_NOTE_ON`, ch 0, `data1`=0x3C, `data2`=0x64, one cycle after the third byte.
- Running status: 0x91 0x40 0x7F 0x40 0x00 → `EV_NOTE_ON` ch 1 (0x40, 0x7F), then `EV_NOTE_OFF` ch 1 (0x40, 0x00).
- 0x90 0x3C 0xF8 0x64, bytes strobed on back-to-back cycles → one `EV_NOTE_ON` (0x3C, 0x64); the real-time byte is invisible.
- 0xF0 0x7E 0x01 0xF7 0x3C 0xB2 0x07 0x50 0xE0 0x00 0x40, checked in this order:
  - SysEx 0xF0 0x7E 0x01 0xF7 → no event.
  - Orphan 0x3C after 0xF7 → `err_count_out`=1.
  - 0xB2 0x07 0x50 → `EV_CC` ch 2 (0x07, 0x50).
  - 0xE0 0x00 0x40 → `EV_PITCH_BEND` ch 0 (LSB 0x00, MSB 0x40).
- 0xC3 0x05 0x90 0x3C 0x64 → no event for the program change, then `EV_NOTE_ON`.
  - Same stream with `OMNI`=0, `CHANNEL`=5 → no events at all.
- Robustness:
  - 300 orphan data bytes after reset → `err_count_out`=255.
  - `rst_in` between 0x90 0x3C and 0x64 → no event, counter=1.
